// File: rtl/interface_hcsr04_multi_if.sv
// Control/result bus between the top-level control FSM (master) and the
// multi-channel HC-SR04 scanner (slave).
interface interface_hcsr04_multi_if #(
  parameter int N_CH   = 2,
  parameter int DIST_W = 12
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              medir;
  logic              continuo;
  logic [DIST_W-1:0] distancia;
  logic [CH_W-1:0]   canal;
  logic              erro;
  logic              valido;
  logic              pronto;
  logic              ocupado;
  logic [3:0]        db_estado;

  modport master (
    output medir, continuo,
    input  distancia, canal, erro, valido, pronto, ocupado, db_estado
  );

  modport slave (
    input  medir, continuo,
    output distancia, canal, erro, valido, pronto, ocupado, db_estado
  );
endinterface

// File: rtl/interface_hcsr04_multi.sv
// Multi-channel HC-SR04 scanner: triggers each sensor in turn, times the
// echo pulse, converts it to whole centimetres and reports echo timeouts.
module interface_hcsr04_multi #(
  parameter int N_CH         = 2,
  parameter int TRIG_CYCLES  = 500,
  parameter int CYC_PER_CM   = 2941,
  parameter int DIST_W       = 12,
  parameter int ECHO_TIMEOUT = 1500000,
  parameter int GAP_CYCLES   = 3000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          echo,
  output logic [N_CH-1:0]          trigger,
  interface_hcsr04_multi_if.slave  bus
);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CYC_W   = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;
  localparam int MAX_A   = (TRIG_CYCLES > ECHO_TIMEOUT) ? TRIG_CYCLES : ECHO_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CYC_PER_CM - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ENVIA_TRIGGER = 4'h2,
    ESPERA_ECHO   = 4'h3,
    MEDIDA        = 4'h4,
    ARMAZENAMENTO = 4'h5,
    INTERVALO     = 4'h6,
    FINAL         = 4'hF
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic              err_q, err_d;
  logic [DIST_W-1:0] distancia_q, distancia_d;
  logic [CH_W-1:0]   canal_q, canal_d;
  logic              erro_q, erro_d;
  logic              valido_q, valido_d;
  logic [N_CH-1:0]   trigger_q, trigger_d;
  logic [N_CH-1:0]   echo_meta_q, echo_meta_d;
  logic [N_CH-1:0]   echo_sync_q, echo_sync_d;
  logic              echo_cur;

  assign echo_cur = echo_sync_q[ch_q];

  // Next-state, counters, result capture and echo synchroniser inputs
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    cm_d        = cm_q;
    err_d       = err_q;
    distancia_d = distancia_q;
    canal_d     = canal_q;
    erro_d      = erro_q;
    valido_d    = 1'b0;
    echo_meta_d = echo;
    echo_sync_d = echo_meta_q;

    case (state_q)
      INICIAL: begin
        if (bus.medir || bus.continuo) begin
          ch_d    = '0;
          state_d = PREPARACAO;
        end
      end
      PREPARACAO: begin
        cnt_d   = '0;
        cyc_d   = '0;
        cm_d    = '0;
        err_d   = 1'b0;
        state_d = ENVIA_TRIGGER;
      end
      ENVIA_TRIGGER: begin
        if (cnt_q == TRIG_LAST) begin
          cnt_d   = '0;
          state_d = ESPERA_ECHO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ESPERA_ECHO: begin
        if (echo_cur) begin
          // The rising clock already counts as the first high clock
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (cm_q != '1) cm_d = cm_q + DIST_W'(1);
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
          cnt_d   = CNT_W'(1);
          state_d = MEDIDA;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ARMAZENAMENTO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEDIDA: begin
        if (!echo_cur) begin
          state_d = ARMAZENAMENTO;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ARMAZENAMENTO;
        end else begin
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (cm_q != '1) cm_d = cm_q + DIST_W'(1);
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARMAZENAMENTO: begin
        distancia_d = err_q ? '1 : cm_q;
        canal_d     = ch_q;
        erro_d      = err_q;
        valido_d    = 1'b1;
        cnt_d       = '0;
        state_d     = INTERVALO;
      end
      INTERVALO: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (ch_q == CH_LAST) begin
            state_d = FINAL;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = PREPARACAO;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINAL: begin
        if (bus.medir || bus.continuo) begin
          ch_d    = '0;
          state_d = PREPARACAO;
        end
      end
      default: state_d = INICIAL;
    endcase

    // Trigger is registered from the next state so it lines up with ENVIA_TRIGGER
    trigger_d = '0;
    if (state_d == ENVIA_TRIGGER) trigger_d = N_CH'(1) << ch_d;
  end

  // State, counter, result and synchroniser registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INICIAL;
      ch_q        <= '0;
      cnt_q       <= '0;
      cyc_q       <= '0;
      cm_q        <= '0;
      err_q       <= 1'b0;
      distancia_q <= '0;
      canal_q     <= '0;
      erro_q      <= 1'b0;
      valido_q    <= 1'b0;
      trigger_q   <= '0;
      echo_meta_q <= '0;
      echo_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      cm_q        <= cm_d;
      err_q       <= err_d;
      distancia_q <= distancia_d;
      canal_q     <= canal_d;
      erro_q      <= erro_d;
      valido_q    <= valido_d;
      trigger_q   <= trigger_d;
      echo_meta_q <= echo_meta_d;
      echo_sync_q <= echo_sync_d;
    end
  end

  assign trigger       = trigger_q;
  assign bus.distancia = distancia_q;
  assign bus.canal     = canal_q;
  assign bus.erro      = erro_q;
  assign bus.valido    = valido_q;
  assign bus.pronto    = (state_q == FINAL);
  assign bus.ocupado   = (state_q != INICIAL) && (state_q != FINAL);
  assign bus.db_estado = state_q;
endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// Directed bench for the two-channel scanner with small timing parameters.
module tb_interface_hcsr04_multi;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] echo;
  logic [1:0] trigger;
  int         echo_left [2];
  int         checks = 0;
  int         errors = 0;

  interface_hcsr04_multi_if #(.N_CH(2), .DIST_W(4)) bus ();

  interface_hcsr04_multi #(
    .N_CH(2), .TRIG_CYCLES(4), .CYC_PER_CM(10), .DIST_W(4),
    .ECHO_TIMEOUT(200), .GAP_CYCLES(8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .echo    (echo),
    .trigger (trigger),
    .bus     (bus)
  );

  typedef struct {
    int w0; int w1;
    int d0; int e0;
    int d1; int e1;
  } vec_t;

  vec_t vecs [6];

  // Free-running clock
  always #5 clock = ~clock;

  // Echo generator: holds each channel high for echo_left rising edges
  initial begin
    echo = '0;
    echo_left[0] = 0;
    echo_left[1] = 0;
    forever begin
      @(posedge clock);
      #2;
      for (int c = 0; c < 2; c++) begin
        if (echo_left[c] > 0) begin
          echo[c] = 1'b1;
          echo_left[c]--;
        end else begin
          echo[c] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pulse_medir();
    bus.medir = 1'b1;
    tick();
    bus.medir = 1'b0;
  endtask

  // mid_action: 0 none, 1 drop continuo in MEDIDA, 2 pulse medir in MEDIDA
  task automatic run_channel(input int ch, input int width, input int exp_dist,
                             input int exp_err, input bit check_gap, input int mid_action);
    int waited;
    int hi_cycles;
    int bad;
    int n;
    int other;
    other = 1 - ch;
    waited = 0;
    while (trigger == 2'b00 && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput("trigger_seen", int'(trigger != 2'b00), 1);
    if (check_gap) checkOutput("gap_valido_to_trigger", waited, 9);
    hi_cycles = 0;
    bad = 0;
    while (trigger[ch] && hi_cycles < 50) begin
      if (trigger[other]) bad++;
      hi_cycles++;
      tick();
    end
    checkOutput("trigger_width", hi_cycles, 4);
    checkOutput("trigger_other_low", bad, 0);
    checkOutput("state_espera", int'(bus.db_estado), 3);
    echo_left[ch] = width;
    n = 0;
    while (!bus.valido && n < 600) begin
      bus.medir = 1'b0;
      if (mid_action != 0 && bus.db_estado == 4'h4) begin
        if (mid_action == 1) bus.continuo = 1'b0;
        else bus.medir = 1'b1;
        mid_action = 0;
      end
      tick();
      n++;
    end
    bus.medir = 1'b0;
    checkOutput("valido_seen", int'(bus.valido), 1);
    checkOutput("canal", int'(bus.canal), ch);
    checkOutput("distancia", int'(bus.distancia), exp_dist);
    checkOutput("erro", int'(bus.erro), exp_err);
  endtask

  task automatic wait_final_and_drain();
    int n;
    n = 0;
    while (!bus.pronto && n < 100) begin
      tick();
      n++;
    end
    checkOutput("pronto", int'(bus.pronto), 1);
    checkOutput("ocupado_idle", int'(bus.ocupado), 0);
    n = 0;
    while ((echo_left[0] > 0 || echo_left[1] > 0) && n < 400) begin
      tick();
      n++;
    end
    repeat (4) tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    pulse_medir();
    run_channel(0, v.w0, v.d0, v.e0, 1'b0, 0);
    run_channel(1, v.w1, v.d1, v.e1, 1'b1, 0);
    wait_final_and_drain();
  endtask

  initial begin
    int n;
    int extra_valido;
    vecs[0] = '{w0: 57,  w1: 35,  d0: 5,  e0: 0, d1: 3,  e1: 0};
    vecs[1] = '{w0: 0,   w1: 35,  d0: 15, e0: 1, d1: 3,  e1: 0};
    vecs[2] = '{w0: 170, w1: 20,  d0: 15, e0: 0, d1: 2,  e1: 0};
    vecs[3] = '{w0: 250, w1: 12,  d0: 15, e0: 1, d1: 1,  e1: 0};
    vecs[4] = '{w0: 9,   w1: 10,  d0: 0,  e0: 0, d1: 1,  e1: 0};
    vecs[5] = '{w0: 199, w1: 200, d0: 15, e0: 0, d1: 15, e1: 1};

    reset = 1'b1;
    bus.medir = 1'b0;
    bus.continuo = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("reset_db_estado", int'(bus.db_estado), 0);
    checkOutput("reset_trigger", int'(trigger), 0);
    checkOutput("reset_valido", int'(bus.valido), 0);
    checkOutput("reset_distancia", int'(bus.distancia), 0);
    checkOutput("reset_canal", int'(bus.canal), 0);
    checkOutput("reset_erro", int'(bus.erro), 0);
    checkOutput("reset_pronto", int'(bus.pronto), 0);
    checkOutput("reset_ocupado", int'(bus.ocupado), 0);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d: echo0=%0d echo1=%0d", i, vecs[i].w0, vecs[i].w1);
      applyStimulus(vecs[i]);
    end

    $display("[TB] continuous mode");
    bus.continuo = 1'b1;
    run_channel(0, 57, 5, 0, 1'b0, 0);
    run_channel(1, 35, 3, 0, 1'b1, 0);
    run_channel(0, 23, 2, 0, 1'b0, 1);
    run_channel(1, 44, 4, 0, 1'b1, 0);
    wait_final_and_drain();
    extra_valido = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valido) extra_valido++;
      tick();
    end
    checkOutput("continuo_stop_valido", extra_valido, 0);
    checkOutput("continuo_stop_state", int'(bus.db_estado), 15);

    $display("[TB] medir while busy");
    pulse_medir();
    run_channel(0, 30, 3, 0, 1'b0, 2);
    run_channel(1, 67, 6, 0, 1'b1, 0);
    wait_final_and_drain();
    extra_valido = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valido || bus.ocupado) extra_valido++;
      tick();
    end
    checkOutput("busy_medir_no_sweep", extra_valido, 0);
    checkOutput("busy_medir_state", int'(bus.db_estado), 15);

    $display("[TB] reset during measurement");
    pulse_medir();
    n = 0;
    while (bus.db_estado != 4'h3 && n < 50) begin
      tick();
      n++;
    end
    echo_left[0] = 100;
    n = 0;
    while (bus.db_estado != 4'h4 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("reached_medida", int'(bus.db_estado), 4);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checkOutput("midreset_db_estado", int'(bus.db_estado), 0);
    checkOutput("midreset_trigger", int'(trigger), 0);
    checkOutput("midreset_valido", int'(bus.valido), 0);
    checkOutput("midreset_distancia", int'(bus.distancia), 0);
    reset = 1'b0;
    echo_left[0] = 0;
    echo_left[1] = 0;
    repeat (10) tick();
    checkOutput("after_reset_idle", int'(bus.db_estado), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
